// File: rtl/bq_coeff_pkg.sv
// bq_coeff_pkg: register offsets, coefficient group geometry and control
// bit positions shared by the biquad coefficient loader.
package bq_coeff_pkg;
   typedef enum logic [2:0] {GRP_BA, GRP_C, GRP_AP, GRP_F, GRP_G, GRP_DFG, GRP_EGF} grp_e;
   localparam int NGRP = int'(GRP_EGF) + 1;
   localparam int NCOEFF_PER_STAGE = 25;
   localparam logic [6:0] OFF_CTRL = 7'h00;
   localparam logic [6:0] OFF_BA = 7'h04;
   localparam logic [6:0] OFF_C = 7'h08;
   localparam logic [6:0] OFF_AP = 7'h0C;
   localparam logic [6:0] OFF_F = 7'h10;
   localparam logic [6:0] OFF_G = 7'h14;
   localparam logic [6:0] OFF_DFG = 7'h18;
   localparam logic [6:0] OFF_EGF = 7'h1C;
   localparam logic [6:0] GRP_OFF [NGRP] = '{OFF_BA, OFF_C, OFF_AP, OFF_F, OFF_G, OFF_DFG, OFF_EGF};
   localparam int GRP_DEPTH [NGRP] = '{2, 4, 2, 7, 8, 1, 1};
   // first element of each group within a stage's packed coefficient slice
   localparam int GRP_BASE [NGRP] = '{0, 2, 6, 8, 15, 23, 24};
   localparam int CTRL_UPDATE = 0;
   localparam int CTRL_BQRST = 1;
   localparam int CTRL_CLEAR = 2;
endpackage

// File: rtl/bq_coeff_group.sv
// bq_coeff_group: staging chain for one coefficient group with wrapping
// write counter, sticky overflow and commit to live outputs.
module bq_coeff_group #(
   parameter int DEPTH = 2,
   parameter int COEFF_W = 18
) (
   input  logic                     wbclk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic                     commit,
   input  logic                     clr,
   input  logic [COEFF_W-1:0]       din,
   output logic [DEPTH*COEFF_W-1:0] live,
   output logic [3:0]               cnt,
   output logic                     ovf,
   output logic                     full
);
   logic [COEFF_W-1:0] stg [DEPTH];
   logic [3:0] idx;
   assign full = cnt == 4'(DEPTH);
   // a write into a full group wraps back to element 0
   assign idx = full ? 4'd0 : cnt;
   always_ff @(posedge wbclk or posedge rst)
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
         live <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr && idx == 4'(i)) stg[i] <= din;
            if (commit) live[i*COEFF_W +: COEFF_W] <= stg[i];
         end
         cnt <= (commit || clr) ? 4'd0 : wr ? idx + 4'd1 : cnt;
         ovf <= clr ? 1'b0 : (wr && full) ? 1'b1 : ovf;
      end
endmodule

// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: wishbone coefficient staging/commit engine with
// per-stage update strobes and timed biquad reset pulses.
module biquad_coeff_loader
   import bq_coeff_pkg::*;
#(
   parameter int NBQ = 2,
   parameter int ADR_W = 8,
   parameter int COEFF_W = 18,
   parameter int RESET_CYCLES = 32
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_i,
   input  logic                               wb_cyc_i,
   input  logic                               wb_stb_i,
   input  logic                               wb_we_i,
   input  logic [3:0]                         wb_sel_i,
   input  logic [ADR_W-1:0]                   wb_adr_i,
   input  logic [31:0]                        wb_dat_i,
   output logic [31:0]                        wb_dat_o,
   output logic                               wb_ack_o,
   output logic [NBQ*NCOEFF_PER_STAGE*COEFF_W-1:0] coeff_o,
   output logic [NBQ-1:0]                     update_o,
   output logic [NBQ-1:0]                     bq_reset_o
);
   localparam int SW = ADR_W - 7;
   localparam int RW = $clog2(RESET_CYCLES + 1);
   logic acc;
   logic [SW-1:0] stage;
   logic [6:0] off;
   logic [NBQ-1:0] ctl_v, upd_v, fail_v, clr_v, bqr_v;
   logic [3:0] cnt [NBQ][NGRP];
   logic [NGRP-1:0] ovf [NBQ];
   logic [NGRP-1:0] full [NBQ];
   logic [NBQ-1:0] err;
   logic [RW-1:0] rcnt [NBQ];
   logic [31:0] rdata;
   logic unused_ok;
   assign unused_ok = &{1'b0, wb_sel_i, wb_dat_i[31:COEFF_W]};
   assign acc = wb_cyc_i && wb_stb_i && !wb_ack_o;
   assign stage = wb_adr_i[ADR_W-1:7];
   assign off = wb_adr_i[6:0];
   for (genvar s = 0; s < NBQ; s++) begin : g_stage
      logic hit;
      assign hit = acc && wb_we_i && stage == SW'(s);
      assign ctl_v[s] = hit && off == OFF_CTRL;
      assign upd_v[s] = ctl_v[s] && wb_dat_i[CTRL_UPDATE] && &full[s];
      assign fail_v[s] = ctl_v[s] && wb_dat_i[CTRL_UPDATE] && !(&full[s]);
      assign clr_v[s] = ctl_v[s] && wb_dat_i[CTRL_CLEAR];
      assign bqr_v[s] = ctl_v[s] && wb_dat_i[CTRL_BQRST];
      assign bq_reset_o[s] = rcnt[s] != '0;
      for (genvar g = 0; g < NGRP; g++) begin : g_grp
         bq_coeff_group #(.DEPTH(GRP_DEPTH[g]), .COEFF_W(COEFF_W)) u_grp (
            .wbclk  (wb_clk_i),
            .rst    (wb_rst_i),
            .wr     (hit && off == GRP_OFF[g]),
            .commit (upd_v[s]),
            .clr    (clr_v[s]),
            .din    (wb_dat_i[COEFF_W-1:0]),
            .live   (coeff_o[(s*NCOEFF_PER_STAGE + GRP_BASE[g])*COEFF_W +: GRP_DEPTH[g]*COEFF_W]),
            .cnt    (cnt[s][g]),
            .ovf    (ovf[s][g]),
            .full   (full[s][g])
         );
      end
   end
   always_comb begin
      rdata = '0;
      for (int s = 0; s < NBQ; s++)
         if (stage == SW'(s)) begin
            if (off == OFF_CTRL) rdata = {17'b0, ovf[s], 6'b0, err[s], &full[s]};
            for (int g = 0; g < NGRP; g++)
               if (off == GRP_OFF[g]) rdata = {28'b0, cnt[s][g]};
         end
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         update_o <= '0;
         err <= '0;
         for (int s = 0; s < NBQ; s++) rcnt[s] <= '0;
      end else begin
         wb_ack_o <= acc;
         if (acc && !wb_we_i) wb_dat_o <= rdata;
         update_o <= upd_v;
         // a failed UPDATE sets ERR unless CLEAR in the same write wipes it
         for (int s = 0; s < NBQ; s++) begin
            err[s] <= clr_v[s] ? 1'b0 : fail_v[s] ? 1'b1 : err[s];
            rcnt[s] <= bqr_v[s] ? RW'(RESET_CYCLES) : rcnt[s] - RW'(rcnt[s] != '0);
         end
      end
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: directed and randomized checks of the coefficient
// loader against a behavioural register model.
module tb_biquad_coeff_loader;
   localparam int NBQ = 2;
   localparam int ADR_W = 8;
   localparam int COEFF_W = 18;
   localparam int RESET_CYCLES = 32;
   localparam int NC = 25;
   localparam int CW = NBQ * NC * COEFF_W;
   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;
   logic wb_cyc_i = 1'b0;
   logic wb_stb_i = 1'b0;
   logic wb_we_i = 1'b0;
   logic [3:0] wb_sel_i = 4'hF;
   logic [ADR_W-1:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic wb_ack_o;
   logic [CW-1:0] coeff_o;
   logic [NBQ-1:0] update_o, bq_reset_o;
   biquad_coeff_loader #(.NBQ(NBQ), .ADR_W(ADR_W), .COEFF_W(COEFF_W), .RESET_CYCLES(RESET_CYCLES)) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_sel_i   (wb_sel_i),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .coeff_o    (coeff_o),
      .update_o   (update_o),
      .bq_reset_o (bq_reset_o)
   );
   always #5 wb_clk_i = ~wb_clk_i;
   int checks = 0;
   int errors = 0;
   int unsigned cyc_cnt = 0;
   int hi [NBQ];
   always @(posedge wb_clk_i) cyc_cnt++;
   always @(negedge wb_clk_i) for (int s = 0; s < NBQ; s++) if (bq_reset_o[s]) hi[s]++;
   // register model: per stage, per group staging list with a fill count
   int depth [7] = '{2, 4, 2, 7, 8, 1, 1};
   int base [7] = '{0, 2, 6, 8, 15, 23, 24};
   logic [COEFF_W-1:0] stg_m [NBQ][7][8];
   int cnt_m [NBQ][7];
   bit ovf_m [NBQ][7];
   bit err_m [NBQ];
   logic [COEFF_W-1:0] live_m [NBQ][NC];
   bit rv [NBQ];
   int unsigned redge [NBQ];
   logic [NBQ-1:0] upd_exp;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic chk_coeff(input string tag, input logic [CW-1:0] o, input logic [CW-1:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, o, e);
      end
   endtask
   function automatic int grp_of(input logic [6:0] off);
      for (int g = 0; g < 7; g++) if (off == 7'(4 * (g + 1))) return g;
      return -1;
   endfunction
   function automatic bit complete(input int s);
      for (int g = 0; g < 7; g++) if (cnt_m[s][g] != depth[g]) return 1'b0;
      return 1'b1;
   endfunction
   function automatic void model_reset();
      for (int s = 0; s < NBQ; s++) begin
         err_m[s] = 0;
         rv[s] = 0;
         for (int k = 0; k < NC; k++) live_m[s][k] = '0;
         for (int g = 0; g < 7; g++) begin
            cnt_m[s][g] = 0;
            ovf_m[s][g] = 0;
            for (int i = 0; i < 8; i++) stg_m[s][g][i] = '0;
         end
      end
   endfunction
   function automatic void model_write(input logic [7:0] adr, input logic [31:0] d);
      int s = int'(adr[7]);
      int g = grp_of(adr[6:0]);
      upd_exp = '0;
      if (adr[6:0] == 7'h00) begin
         if (d[0] && complete(s)) begin
            for (int h = 0; h < 7; h++) begin
               for (int i = 0; i < depth[h]; i++) live_m[s][base[h] + i] = stg_m[s][h][i];
               cnt_m[s][h] = 0;
            end
            upd_exp[s] = 1'b1;
         end else if (d[0]) err_m[s] = 1;
         if (d[2]) begin
            err_m[s] = 0;
            for (int h = 0; h < 7; h++) begin
               cnt_m[s][h] = 0;
               ovf_m[s][h] = 0;
            end
         end
         if (d[1]) begin
            rv[s] = 1;
            redge[s] = cyc_cnt;
         end
      end else if (g >= 0) begin
         if (cnt_m[s][g] == depth[g]) begin
            cnt_m[s][g] = 0;
            ovf_m[s][g] = 1;
         end
         stg_m[s][g][cnt_m[s][g]] = d[COEFF_W-1:0];
         cnt_m[s][g]++;
      end
   endfunction
   function automatic logic [31:0] model_read(input logic [7:0] adr);
      int s = int'(adr[7]);
      int g = grp_of(adr[6:0]);
      logic [31:0] r = '0;
      if (adr[6:0] == 7'h00) begin
         r[0] = complete(s);
         r[1] = err_m[s];
         for (int h = 0; h < 7; h++) r[8 + h] = ovf_m[s][h];
      end else if (g >= 0) r = 32'(cnt_m[s][g]);
      return r;
   endfunction
   function automatic logic [CW-1:0] exp_coeff();
      logic [CW-1:0] v = '0;
      for (int s = 0; s < NBQ; s++)
         for (int k = 0; k < NC; k++) v[(s * NC + k) * COEFF_W +: COEFF_W] = live_m[s][k];
      return v;
   endfunction
   task automatic check_state();
      logic [NBQ-1:0] eb;
      for (int s = 0; s < NBQ; s++) eb[s] = rv[s] && (cyc_cnt - redge[s] < 32'(RESET_CYCLES));
      chk("bq_reset", 32'(bq_reset_o), 32'(eb));
      chk_coeff("coeff", coeff_o, exp_coeff());
   endtask
   task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat, output logic [NBQ-1:0] upd);
      int n = 0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      do begin
         @(negedge wb_clk_i);
         n++;
      end while (!wb_ack_o && n < 8);
      chk("ack", 32'(wb_ack_o), 32'd1);
      rdat = wb_dat_o;
      upd = update_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
   endtask
   task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
      logic [31:0] r;
      logic [NBQ-1:0] u;
      bus(1'b1, adr, dat, r, u);
      model_write(adr, dat);
      chk("update", 32'(u), 32'(upd_exp));
      check_state();
   endtask
   task automatic rd(input logic [7:0] adr, output logic [31:0] r);
      logic [NBQ-1:0] u;
      bus(1'b0, adr, 32'd0, r, u);
      chk($sformatf("read_%02h", adr), r, model_read(adr));
   endtask
   task automatic load(input int s, input int v0, input int skip);
      int k = 0;
      for (int g = 0; g < 7; g++)
         for (int i = 0; i < depth[g]; i++) begin
            if (g != skip) wr(8'(s * 128 + 4 * (g + 1)), 32'(v0 + k));
            k++;
         end
   endtask
   initial begin
      logic [31:0] r;
      int sel;
      model_reset();
      repeat (3) @(negedge wb_clk_i);
      chk("rst_ack", 32'(wb_ack_o), 32'd0);
      chk("rst_upd", 32'(update_o), 32'd0);
      chk("rst_bq", 32'(bq_reset_o), 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk_coeff("rst_coeff", coeff_o, '0);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      // full load and commit on stage 0
      load(0, 1, -1);
      wr(8'h00, 32'h1);
      chk("t1_upd_pulse", 32'(update_o), 32'h1);
      @(negedge wb_clk_i);
      chk("t1_upd_drop", 32'(update_o), 32'h0);
      chk("t1_e0", 32'(coeff_o[0 +: COEFF_W]), 32'd1);
      chk("t1_e24", 32'(coeff_o[24 * COEFF_W +: COEFF_W]), 32'd25);
      rd(8'h00, r);
      chk("t1_status", r, 32'h0);
      rd(8'h08, r);
      chk("t1_cnt", r, 32'h0);
      // incomplete load: no commit, ERR set
      load(0, 101, 6);
      wr(8'h00, 32'h1);
      rd(8'h00, r);
      chk("t2_status", r, 32'h2);
      chk("t2_e0_kept", 32'(coeff_o[0 +: COEFF_W]), 32'd1);
      wr(8'h00, 32'h4);
      // overflow on stage 1 BA
      wr(8'h84, 32'd7);
      wr(8'h84, 32'd8);
      wr(8'h84, 32'd9);
      rd(8'h84, r);
      chk("t3_cnt", r, 32'h1);
      rd(8'h80, r);
      chk("t3_status", r, 32'h100);
      rd(8'h00, r);
      chk("t3_stage0", r, 32'h0);
      wr(8'h84, 32'd10);
      load(1, 200, 0);
      wr(8'h80, 32'h1);
      chk("t3_s1_e0", 32'(coeff_o[NC * COEFF_W +: COEFF_W]), 32'd9);
      chk("t3_s1_e1", 32'(coeff_o[(NC + 1) * COEFF_W +: COEFF_W]), 32'd10);
      // restarted reset pulse on stage 1
      hi[0] = 0;
      hi[1] = 0;
      wr(8'h80, 32'h2);
      repeat (9) @(negedge wb_clk_i);
      wr(8'h80, 32'h2);
      repeat (60) @(negedge wb_clk_i);
      chk("t4_hi1", 32'(hi[1]), 32'd42);
      chk("t4_hi0", 32'(hi[0]), 32'd0);
      // commit and clear combined
      wr(8'h00, 32'h4);
      wr(8'h00, 32'h1);
      wr(8'h18, 32'd5);
      wr(8'h18, 32'd6);
      rd(8'h00, r);
      chk("t5_flags", r, 32'h2002);
      load(0, 300, 5);
      wr(8'h00, 32'h5);
      rd(8'h00, r);
      chk("t5_status", r, 32'h0);
      // reset between strobe and ack
      wr(8'h80, 32'h2);
      wr(8'h10, 32'h55);
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i = 1'b1;
      wb_adr_i = 8'h10;
      wb_dat_i = 32'h66;
      #2 wb_rst_i = 1'b1;
      #1 model_reset();
      for (int i = 0; i < 3; i++) begin
         chk("t6_ack", 32'(wb_ack_o), 32'd0);
         chk("t6_upd", 32'(update_o), 32'd0);
         chk("t6_bq", 32'(bq_reset_o), 32'd0);
         chk("t6_dat", wb_dat_o, 32'd0);
         chk_coeff("t6_coeff", coeff_o, '0);
         @(negedge wb_clk_i);
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("t6_ack_after", 32'(wb_ack_o), 32'd0);
      chk("t6_bq_after", 32'(bq_reset_o), 32'd0);
      rd(8'h10, r);
      chk("t6_cnt", r, 32'h0);
      // randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 55) wr({1'($urandom_range(0, 1)), 7'(4 * $urandom_range(1, 7))}, $urandom);
         else if (sel < 67) wr({1'($urandom_range(0, 1)), 7'h00}, 32'($urandom_range(0, 7)));
         else if (sel < 72) wr({1'($urandom_range(0, 1)), 7'($urandom_range(0, 127))}, $urandom);
         else if (sel < 87) rd({1'($urandom_range(0, 1)), 7'(4 * $urandom_range(0, 8))}, r);
         else if (sel < 92) rd({1'($urandom_range(0, 1)), 7'($urandom_range(0, 127))}, r);
         else if (sel < 96) load(int'($urandom_range(0, 1)), int'($urandom_range(0, 4000)), -1);
         else repeat ($urandom_range(1, 20)) @(negedge wb_clk_i);
      end
      check_state();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
